// File: rtl/jpeg_huffman_encoder_pkg.sv
// Shared definitions for the JPEG Huffman bit encoder: FSM encoding, table geometry, entry layout.
package jpeg_huffman_encoder_pkg;

    localparam int unsigned HUFF_MAX_LEN = 16;
    localparam int unsigned TBL_DEPTH    = 256;
    localparam int unsigned SYM_W        = 8;
    localparam int unsigned LEN_W        = 5;
    localparam int unsigned POS_W        = 3;
    localparam int unsigned BYTE_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CODE  = 2'd1,
        EXTRA = 2'd2,
        PAD   = 2'd3
    } enc_state_t;

    typedef struct packed {
        logic [HUFF_MAX_LEN-1:0] code;
        logic [LEN_W-1:0]        len;
    } tbl_entry_t;

endpackage

// File: rtl/jpeg_bit_serializer.sv
// MSB-first serializer: loads a right-aligned value of i_len bits and shifts it out under valid/ready.
module jpeg_bit_serializer
    import jpeg_huffman_encoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [HUFF_MAX_LEN-1:0] i_value,
    input  logic [LEN_W-1:0]        i_len,
    input  logic                    i_ready,
    output logic                    o_bit,
    output logic                    o_valid,
    output logic                    o_done_c
);

    logic [HUFF_MAX_LEN-1:0] r_shift;
    logic [LEN_W-1:0]        r_cnt;
    logic                    r_valid;
    logic                    w_xfer;

    assign w_xfer   = r_valid & i_ready;
    assign o_done_c = w_xfer && (r_cnt == LEN_W'(1));
    assign o_bit    = r_shift[HUFF_MAX_LEN-1];
    assign o_valid  = r_valid;

    // Load left-justifies the code so the current bit is always the shifter MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_value << (LEN_W'(HUFF_MAX_LEN) - i_len);
            r_cnt   <= i_len;
            r_valid <= (i_len != '0);
        end else if (w_xfer) begin
            r_shift <= {r_shift[HUFF_MAX_LEN-2:0], 1'b0};
            r_cnt   <= r_cnt - LEN_W'(1);
            r_valid <= (r_cnt != LEN_W'(1));
        end
    end

endmodule

// File: rtl/jpeg_huffman_encoder.sv
// Table-driven JPEG Huffman encoder: symbol -> code bits, then raw extra bits, with pad-to-byte flush.
module jpeg_huffman_encoder
    import jpeg_huffman_encoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tbl_we,
    input  logic [SYM_W-1:0]        tbl_addr,
    input  logic [HUFF_MAX_LEN-1:0] tbl_code,
    input  logic [LEN_W-1:0]        tbl_len,
    input  logic [SYM_W-1:0]        sym_in,
    input  logic [HUFF_MAX_LEN-1:0] extra_bits,
    input  logic [LEN_W-1:0]        extra_len,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    input  logic                    flush,
    output logic                    bit_out,
    output logic                    bit_valid,
    input  logic                    bit_ready,
    output logic                    flush_done,
    output logic                    err
);

    tbl_entry_t              r_tbl [TBL_DEPTH];
    enc_state_t              r_state;
    enc_state_t              w_state_nxt;
    logic                    r_flush_pend;
    logic [POS_W-1:0]        r_pos;
    logic                    r_sym_ready;
    logic                    r_flush_done;
    logic                    r_err;
    logic [HUFF_MAX_LEN-1:0] r_extra_bits;
    logic [LEN_W-1:0]        r_extra_len;

    tbl_entry_t              w_entry;
    logic                    w_accept;
    logic                    w_load;
    logic [HUFF_MAX_LEN-1:0] w_load_val;
    logic [LEN_W-1:0]        w_load_len;
    logic                    w_latch_extra;
    logic                    w_pend_clr;
    logic                    w_pend_nxt;
    logic                    w_fdone_nxt;
    logic                    w_err_nxt;
    logic                    w_ser_done;
    logic                    w_ser_bit;
    logic                    w_ser_valid;

    assign w_entry  = r_tbl[sym_in];
    assign w_accept = sym_valid & r_sym_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
                r_tbl[i] <= '0;
            end
        end else if (tbl_we) begin
            r_tbl[tbl_addr] <= '{code: tbl_code, len: tbl_len};
        end
    end

    // Next-state and serializer-load decode; a pending flush outranks new symbols in IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_load_val    = '0;
        w_load_len    = '0;
        w_latch_extra = 1'b0;
        w_pend_clr    = 1'b0;
        w_fdone_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_flush_pend) begin
                    if (r_pos == '0) begin
                        w_pend_clr  = 1'b1;
                        w_fdone_nxt = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_load_val  = '1;
                        w_load_len  = LEN_W'(BYTE_BITS) - LEN_W'(r_pos);
                        w_state_nxt = PAD;
                    end
                end else if (w_accept) begin
                    w_latch_extra = 1'b1;
                    if (w_entry.len == '0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_load_val  = w_entry.code;
                        w_load_len  = w_entry.len;
                        w_state_nxt = CODE;
                    end
                end
            end
            CODE: begin
                if (w_ser_done) begin
                    if (r_extra_len != '0) begin
                        w_load      = 1'b1;
                        w_load_val  = r_extra_bits;
                        w_load_len  = r_extra_len;
                        w_state_nxt = EXTRA;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            EXTRA: begin
                if (w_ser_done) begin
                    w_state_nxt = IDLE;
                end
            end
            PAD: begin
                if (w_ser_done) begin
                    w_pend_clr  = 1'b1;
                    w_fdone_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_pend_nxt = flush | (r_flush_pend & ~w_pend_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_flush_pend <= 1'b0;
            r_pos        <= '0;
            r_sym_ready  <= 1'b0;
            r_flush_done <= 1'b0;
            r_err        <= 1'b0;
            r_extra_bits <= '0;
            r_extra_len  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= w_pend_nxt;
            r_sym_ready  <= (w_state_nxt == IDLE) && !w_pend_nxt;
            r_flush_done <= w_fdone_nxt;
            r_err        <= w_err_nxt;
            if (w_ser_valid && bit_ready) begin
                r_pos <= r_pos + POS_W'(1);
            end
            if (w_latch_extra) begin
                r_extra_bits <= extra_bits;
                r_extra_len  <= extra_len;
            end
        end
    end

    jpeg_bit_serializer u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_value  (w_load_val),
        .i_len    (w_load_len),
        .i_ready  (bit_ready),
        .o_bit    (w_ser_bit),
        .o_valid  (w_ser_valid),
        .o_done_c (w_ser_done)
    );

    assign bit_out    = w_ser_bit;
    assign bit_valid  = w_ser_valid;
    assign sym_ready  = r_sym_ready;
    assign flush_done = r_flush_done;
    assign err        = r_err;

endmodule

// File: tb/tb_jpeg_huffman_encoder.sv
// Directed bench for jpeg_huffman_encoder; inputs change and outputs are sampled on the falling edge.
module tb_jpeg_huffman_encoder;

    logic        clk;
    logic        rst_n;
    logic        tbl_we;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_code;
    logic [4:0]  tbl_len;
    logic [7:0]  sym_in;
    logic [15:0] extra_bits;
    logic [4:0]  extra_len;
    logic        sym_valid;
    logic        sym_ready;
    logic        flush;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        flush_done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    jpeg_huffman_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_code   (tbl_code),
        .tbl_len    (tbl_len),
        .sym_in     (sym_in),
        .extra_bits (extra_bits),
        .extra_len  (extra_len),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .flush      (flush),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .flush_done (flush_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_tbl(input logic [7:0] a, input logic [15:0] c, input logic [4:0] l);
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    // Presents one symbol for a single cycle; returns sym_ready as seen while offered.
    task automatic send(input logic [7:0] s, input logic [15:0] eb, input logic [4:0] el,
                        output logic rdy_seen);
        @(negedge clk);
        sym_in = s; extra_bits = eb; extra_len = el; sym_valid = 1'b1;
        rdy_seen = sym_ready;
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    // Gathers n bits with bit_ready=1; ends on the falling edge of the last bit cycle.
    task automatic collect(input int n, output logic [31:0] bits, output int got,
                           output int first, output int last);
        bits = '0; got = 0; first = -1; last = -1;
        bit_ready = 1'b1;
        for (int c = 0; c < 64 && got < n; c++) begin
            if (c > 0) @(negedge clk);
            if (bit_valid) begin
                bits = {bits[30:0], bit_out};
                if (got == 0) first = c;
                last = c;
                got++;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({sym_ready, bit_valid, bit_out, flush_done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {sym_ready, bit_valid, bit_out, flush_done, err});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sym_ready !== 1'b1 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0",
                     sym_ready, bit_valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] bits; int got, first, last; logic rdy;
        write_tbl(8'h01, 16'h0002, 5'd3);
        send(8'h01, 16'h0003, 5'd2, rdy);
        collect(5, bits, got, first, last);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (sym_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_blocks_ready: got %b expected 0", sym_ready);
        end
        collect(3, bits, got, first, last);
        n_tests++;
        if (got !== 3 || bits[2:0] !== 3'b111) begin
            n_fail++;
            $display("FAIL flush_pad_bits: got %0d bits %b expected 3 bits 111", got, bits[2:0]);
        end
        @(negedge clk);
        n_tests++;
        if (flush_done !== 1'b1 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done_pad: got done=%b valid=%b expected done=1 valid=0",
                     flush_done, bit_valid);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (bit_valid !== 1'b0 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_aligned_wait: got valid=%b done=%b expected 0 0",
                     bit_valid, flush_done);
        end
        @(negedge clk);
        n_tests++;
        if (flush_done !== 1'b1 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_aligned_done: got done=%b valid=%b expected done=1 valid=0",
                     flush_done, bit_valid);
        end
    endtask

    task automatic test_code_extra();
        logic [31:0] bits; int got, first, last; logic rdy;
        write_tbl(8'h01, 16'h0002, 5'd3);
        send(8'h01, 16'h0003, 5'd2, rdy);
        n_tests++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_sym_ready: got %b expected 1", rdy);
        end
        collect(5, bits, got, first, last);
        n_tests++;
        if (got !== 5 || bits[4:0] !== 5'b01011) begin
            n_fail++;
            $display("FAIL ce_bits: got %0d bits %b expected 5 bits 01011", got, bits[4:0]);
        end
        n_tests++;
        if (first !== 0 || last !== 4) begin
            n_fail++;
            $display("FAIL ce_timing: got first=%0d last=%0d expected 0 4", first, last);
        end
        @(negedge clk);
        n_tests++;
        if (bit_valid !== 1'b0 || sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_bubble: got valid=%b ready=%b expected 0 1", bit_valid, sym_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] bits; int got, last, unstable; logic rdy;
        logic pv, pr, pb, t;
        write_tbl(8'hF0, 16'h07F9, 5'd11);
        bit_ready = 1'b1;
        send(8'hF0, 16'h0000, 5'd0, rdy);
        bits = '0; got = 0; last = -1; unstable = 0;
        pv = 1'b0; pr = 1'b1; pb = 1'b0; t = 1'b1;
        for (int c = 0; c < 200 && got < 11; c++) begin
            if (c > 0) @(negedge clk);
            bit_ready = t;
            if (pv && !pr && (bit_valid !== 1'b1 || bit_out !== pb)) unstable++;
            if (bit_valid && bit_ready) begin
                bits = {bits[30:0], bit_out};
                got++;
                last = c;
            end
            pv = bit_valid; pr = bit_ready; pb = bit_out; t = ~t;
        end
        n_tests++;
        if (got !== 11 || bits[10:0] !== 11'b11111111001) begin
            n_fail++;
            $display("FAIL bp_bits: got %0d bits %b expected 11 bits 11111111001", got, bits[10:0]);
        end
        n_tests++;
        if (unstable !== 0 || last !== 20) begin
            n_fail++;
            $display("FAIL bp_hold: got unstable=%0d last=%0d expected 0 20", unstable, last);
        end
        @(negedge clk);
        bit_ready = 1'b1;
        n_tests++;
        if (bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_extra: got valid=%b expected 0", bit_valid);
        end
    endtask

    task automatic test_err();
        logic rdy;
        write_tbl(8'h05, 16'h0000, 5'd0);
        send(8'h05, 16'h0000, 5'd0, rdy);
        n_tests++;
        if (err !== 1'b1 || bit_valid !== 1'b0 || sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_pulse: got err=%b valid=%b ready=%b expected 1 0 1",
                     err, bit_valid, sym_ready);
        end
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_single: got err=%b valid=%b expected 0 0", err, bit_valid);
        end
    endtask

    task automatic test_table_rewrite();
        logic [31:0] bits; int got, first, last; logic rdy; logic b0;
        send(8'h01, 16'h0000, 5'd0, rdy);
        b0 = bit_out;
        tbl_we = 1'b1; tbl_addr = 8'h01; tbl_code = 16'h0005; tbl_len = 5'd3;
        @(negedge clk);
        tbl_we = 1'b0;
        collect(2, bits, got, first, last);
        n_tests++;
        if ({b0, bits[1:0]} !== 3'b010) begin
            n_fail++;
            $display("FAIL rw_old_code: got %b expected 010", {b0, bits[1:0]});
        end
        send(8'h01, 16'h0000, 5'd0, rdy);
        collect(3, bits, got, first, last);
        n_tests++;
        if (got !== 3 || bits[2:0] !== 3'b101) begin
            n_fail++;
            $display("FAIL rw_new_code: got %0d bits %b expected 3 bits 101", got, bits[2:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] bits; int got, first, last; logic rdy;
        send(8'hF0, 16'h0000, 5'd0, rdy);
        collect(2, bits, got, first, last);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bit_valid, bit_out, sym_ready, flush_done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL rm_async: got %b expected 00000",
                     {bit_valid, bit_out, sym_ready, flush_done, err});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sym_ready !== 1'b1 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_release: got ready=%b valid=%b expected 1 0", sym_ready, bit_valid);
        end
        send(8'hF0, 16'h0000, 5'd0, rdy);
        n_tests++;
        if (err !== 1'b1 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_table_cleared: got err=%b valid=%b expected 1 0", err, bit_valid);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (flush_done !== 1'b1 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_pos_zero: got done=%b valid=%b expected 1 0", flush_done, bit_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
        sym_in = '0; extra_bits = '0; extra_len = '0; sym_valid = 1'b0;
        flush = 1'b0; bit_ready = 1'b1;
        test_reset();
        test_flush();
        test_code_extra();
        test_backpressure();
        test_err();
        test_table_rewrite();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
